lag_window_engine: RTL and testbench



---
 rtl/lag_window_pkg.sv | 36 +++
 rtl/lag_window_engine_mpy32_dpf.sv | 44 ++++
 rtl/lag_window_engine.sv | 168 ++++++++++++++++
 tb/tb_lag_window_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_window_pkg.sv
// Shared constants, FSM encoding and G.729 lag-window tables for the lag-window engine.
package lag_window_pkg;

    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32 = 32'h8000_0000;
    localparam logic [15:0] MAX_16 = 16'h7FFF;
    localparam logic [15:0] MIN_16 = 16'h8000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StC1,
        StC2,
        StC3,
        StWrite,
        StDone
    } lw_state_e;

    localparam int unsigned LAG_TAB_LEN = 10;

    // High and low words of the G.729 lag window, w[i] = lag_h[i]*2^16 + lag_l[i]*2.
    localparam logic [15:0] LAG_H [LAG_TAB_LEN] = '{
        16'd32728, 16'd32619, 16'd32438, 16'd32187, 16'd31867,
        16'd31480, 16'd31029, 16'd30517, 16'd29946, 16'd29321
    };
    localparam logic [15:0] LAG_L [LAG_TAB_LEN] = '{
        16'd11904, 16'd17280, 16'd30720, 16'd25856, 16'd24192,
        16'd28992, 16'd24384, 16'd7360,  16'd19520, 16'd14784
    };

    function automatic logic [31:0] lag_coef(input int unsigned i);
        return {LAG_H[i], LAG_L[i]};
    endfunction

endpackage

// File: rtl/lag_window_engine_mpy32_dpf.sv
// Combinational saturating L_mult / mult / L_add step of the double-precision multiply.
module mpy32_dpf
    import lag_window_pkg::*;
(
    input  logic        first_i,
    input  logic [15:0] lm_a_i,
    input  logic [15:0] lm_b_i,
    input  logic [15:0] m_a_i,
    input  logic [15:0] m_b_i,
    input  logic [31:0] acc_i,
    input  logic [15:0] p_i,
    output logic [31:0] acc_o,
    output logic [15:0] p_o,
    output logic        sat_o
);

    logic signed [31:0] lm_prod;
    logic signed [31:0] m_prod;
    logic        [32:0] sum;
    logic        [31:0] lmult_res;
    logic        [31:0] ladd_res;
    logic               lm_sat;
    logic               m_sat;
    logic               add_sat;

    always_comb begin
        lm_prod   = $signed({{16{lm_a_i[15]}}, lm_a_i}) * $signed({{16{lm_b_i[15]}}, lm_b_i});
        lm_sat    = (lm_prod == 32'sh4000_0000);
        lmult_res = lm_sat ? MAX_32 : {lm_prod[30:0], 1'b0};

        // Bits [30:15] are the arithmetic >>>15 result whenever it fits in 16 bits.
        m_prod = $signed({{16{m_a_i[15]}}, m_a_i}) * $signed({{16{m_b_i[15]}}, m_b_i});
        m_sat  = (m_prod == 32'sh4000_0000);
        p_o    = m_sat ? MAX_16 : m_prod[30:15];

        sum      = {acc_i[31], acc_i} + {{16{p_i[15]}}, p_i, 1'b0};
        add_sat  = sum[32] ^ sum[31];
        ladd_res = add_sat ? (sum[32] ? MIN_32 : MAX_32) : sum[31:0];

        acc_o = first_i ? lmult_res : ladd_res;
        sat_o = (first_i ? lm_sat : add_sat) | m_sat;
    end

endmodule

// File: rtl/lag_window_engine.sv
// Lag-window stage: r'[i] = Mpy_32(r[i], w[i-1]) for i = 1..ORDER over the shared scratch RAM.
// Optional sticky saturation flag built only when LAG_WINDOW_SAT_FLAG_EN is defined.
module lag_window_engine
    import lag_window_pkg::*;
#(
    parameter int unsigned ORDER    = 10,
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] memReadAddr,
    input  logic [31:0]       memIn,
    output logic              memWriteEn,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [31:0]       memOut,
    output logic [4:0]        coefAddr,
    input  logic [31:0]       coefIn,
    output logic              satFlag
);

    lw_state_e   state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [15:0] rh_q, rh_d;
    logic [14:0] rl_q, rl_d;
    logic [31:0] coef_q, coef_d;
    logic [31:0] acc_q, acc_d;
    logic [15:0] p_q, p_d;

    logic [31:0] unit_acc;
    logic [15:0] unit_p;
    logic        unit_sat;
    logic        in_c1;
    logic        mem_lsb_unused;

    // r_l keeps only bits [15:1]; the LSB of the low word is dropped.
    assign mem_lsb_unused = memIn[0];
    assign in_c1          = (state_q == StC1);

    mpy32_dpf u_mpy (
        .first_i (in_c1),
        .lm_a_i  (rh_q),
        .lm_b_i  (coef_q[31:16]),
        .m_a_i   (in_c1 ? rh_q : {1'b0, rl_q}),
        .m_b_i   (in_c1 ? coef_q[15:0] : coef_q[31:16]),
        .acc_i   (acc_q),
        .p_i     (p_q),
        .acc_o   (unit_acc),
        .p_o     (unit_p),
        .sat_o   (unit_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 5'd1;
            rh_q    <= '0;
            rl_q    <= '0;
            coef_q  <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rh_q    <= rh_d;
            rl_q    <= rl_d;
            coef_q  <= coef_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rh_d         = rh_q;
        rl_d         = rl_q;
        coef_d       = coef_q;
        acc_d        = acc_q;
        p_d          = p_q;
        busy         = 1'b0;
        done         = 1'b0;
        memReadAddr  = '0;
        coefAddr     = '0;
        memWriteEn   = 1'b0;
        memWriteAddr = '0;
        memOut       = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    idx_d   = 5'd1;
                end
            end
            StFetch: begin
                busy        = 1'b1;
                memReadAddr = ADDR_W'(IN_BASE) + ADDR_W'(idx_q);
                coefAddr    = idx_q - 5'd1;
                state_d     = StWait;
            end
            StWait: begin
                busy    = 1'b1;
                rh_d    = memIn[31:16];
                rl_d    = memIn[15:1];
                coef_d  = coefIn;
                state_d = StC1;
            end
            StC1, StC2: begin
                busy    = 1'b1;
                acc_d   = unit_acc;
                p_d     = unit_p;
                state_d = in_c1 ? StC2 : StC3;
            end
            StC3: begin
                busy    = 1'b1;
                acc_d   = unit_acc;
                state_d = StWrite;
            end
            StWrite: begin
                busy         = 1'b1;
                memWriteEn   = 1'b1;
                memWriteAddr = ADDR_W'(OUT_BASE) + ADDR_W'(idx_q);
                memOut       = acc_q;
                if (idx_q == 5'(ORDER)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = StFetch;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef LAG_WINDOW_SAT_FLAG_EN
    logic sat_q;
    logic in_calc;

    assign in_calc = (state_q == StC1) || (state_q == StC2) || (state_q == StC3);

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            sat_q <= 1'b0;
        end else if (in_calc && unit_sat) begin
            sat_q <= 1'b1;
        end
    end

    assign satFlag = sat_q;
`else
    logic sat_unused;

    assign sat_unused = unit_sat;
    assign satFlag    = 1'b0;
`endif

endmodule

// File: tb/tb_lag_window_engine.sv
// Directed, table-driven bench for lag_window_engine: in-place and separate-buffer instances.
module tb_lag_window_engine;

    localparam int ORD   = 10;
    localparam int AW    = 7;
    localparam int IN_A  = 32;
    localparam int OUT_B = 48;
    localparam int NV    = 9;
    localparam logic [31:0] R0_WORD   = 32'h1234_5678;
    localparam logic [31:0] SENT_WORD = 32'hCAFE_0000;

`ifdef LAG_WINDOW_SAT_FLAG_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] coef;
        logic [31:0] exp;
        logic        sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b, we_a, we_b, sat_a, sat_b;
    logic [AW-1:0] raddr_a, raddr_b, waddr_a, waddr_b;
    logic [31:0] rdata_a, rdata_b, wdata_a, wdata_b, cdata_a, cdata_b;
    logic [4:0] caddr_a, caddr_b;

    logic [31:0] mem_a [0:127];
    logic [31:0] mem_b [0:127];
    logic [31:0] fill_r;
    logic [31:0] coef_val;
    logic        fill_en;

    int cyc = 0;
    int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int bad_wr_a = 0, bad_wr_b = 0, addr_err = 0;
    int n_checks = 0, n_fail = 0;
    int c0;

    always #5 clk = ~clk;

    lag_window_engine #(
        .ORDER(ORD), .ADDR_W(AW), .IN_BASE(IN_A), .OUT_BASE(IN_A)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .memReadAddr(raddr_a), .memIn(rdata_a), .memWriteEn(we_a), .memWriteAddr(waddr_a),
        .memOut(wdata_a), .coefAddr(caddr_a), .coefIn(cdata_a), .satFlag(sat_a)
    );

    lag_window_engine #(
        .ORDER(ORD), .ADDR_W(AW), .IN_BASE(IN_A), .OUT_BASE(OUT_B)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .memReadAddr(raddr_b), .memIn(rdata_b), .memWriteEn(we_b), .memWriteAddr(waddr_b),
        .memOut(wdata_b), .coefAddr(caddr_b), .coefIn(cdata_b), .satFlag(sat_b)
    );

    function automatic logic [31:0] fill_word(input int k);
        if (k == 0) return R0_WORD;
        if (k <= ORD) return fill_r;
        return SENT_WORD ^ 32'(k);
    endfunction

    // Scratch RAM and coefficient ROM models, one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fill_en) begin
            for (int k = 0; k < 32; k++) begin
                mem_a[IN_A + k] <= fill_word(k);
                mem_b[IN_A + k] <= fill_word(k);
            end
        end else begin
            if (we_a) mem_a[waddr_a] <= wdata_a;
            if (we_b) mem_b[waddr_b] <= wdata_b;
        end
        rdata_a <= mem_a[raddr_a];
        rdata_b <= mem_b[raddr_b];
        cdata_a <= (caddr_a < 5'(ORD)) ? coef_val : 32'h0;
        cdata_b <= (caddr_b < 5'(ORD)) ? coef_val : 32'h0;
    end

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (we_a) begin
            wr_cnt_a++;
            if (int'(waddr_a) <= IN_A || int'(waddr_a) > IN_A + ORD) bad_wr_a++;
        end
        if (we_b) begin
            wr_cnt_b++;
            if (int'(waddr_b) <= OUT_B || int'(waddr_b) > OUT_B + ORD) bad_wr_b++;
        end
        if (raddr_a != '0 && int'(caddr_a) != int'(raddr_a) - IN_A - 1) addr_err++;
        if (raddr_b != '0 && int'(caddr_b) != int'(raddr_b) - IN_A - 1) addr_err++;
    end

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: actual %h, required %h", name, tag, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] r, input logic [31:0] c);
        @(posedge clk); #1;
        fill_r   = r;
        coef_val = c;
        fill_en  = 1'b1;
        @(posedge clk); #1;
        fill_en  = 1'b0;
    endtask

    task automatic pulse(input bit sel_b);
        c0 = cyc;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (sel_b ? done_b : done_a) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    vec_t vecs [NV];

    initial begin
        int lat, wb, db, bad;

        vecs[0] = '{r: 32'h4000_0000, coef: 32'h4000_0000, exp: 32'h2000_0000, sat: 1'b0};
        vecs[1] = '{r: 32'h7FFF_FFFF, coef: 32'h7FFF_7FFF, exp: 32'h7FFF_FFFA, sat: 1'b0};
        vecs[2] = '{r: 32'h8000_0000, coef: 32'h8000_0000, exp: 32'h7FFF_FFFF, sat: 1'b1};
        vecs[3] = '{r: 32'h0000_0000, coef: 32'h7FFF_7FFF, exp: 32'h0000_0000, sat: 1'b0};
        vecs[4] = '{r: 32'hC000_0000, coef: 32'h4000_0000, exp: 32'hE000_0000, sat: 1'b0};
        vecs[5] = '{r: 32'h0001_0002, coef: 32'h7FFF_0000, exp: 32'h0000_FFFE, sat: 1'b0};
        vecs[6] = '{r: 32'h7FFF_FFFF, coef: 32'h8000_8000, exp: 32'h8000_0000, sat: 1'b1};
        vecs[7] = '{r: 32'h8000_0000, coef: 32'h0000_8000, exp: 32'h0000_FFFE, sat: 1'b1};
        vecs[8] = '{r: 32'hFFFF_0000, coef: 32'h0001_0001, exp: 32'hFFFF_FFFC, sat: 1'b0};

        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        fill_en  = 1'b0;
        fill_r   = '0;
        coef_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", 0, 32'({busy_a, done_a, we_a, sat_a, busy_b, done_b, we_b}), 32'd0);
        check("rst_addr", 0, 32'({raddr_a, waddr_a, caddr_a}), 32'd0);
        check("rst_data", 0, wdata_a, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table-driven in-place runs
        for (int v = 0; v < NV; v++) begin
            fill(vecs[v].r, vecs[v].coef);
            wb = wr_cnt_a;
            pulse(1'b0);
            check("busy_after_start", v, 32'(busy_a), 32'd1);
            wait_done(1'b0, lat);
            check("done_latency", v, 32'(lat), 32'd61);
            check("sat_flag", v, 32'(sat_a), 32'(vecs[v].sat & SAT_EN));
            for (int i = 1; i <= ORD; i++) check("elem", v * 100 + i, mem_a[IN_A + i], vecs[v].exp);
            check("r0_kept", v, mem_a[IN_A], R0_WORD);
            check("above_order_kept", v, mem_a[IN_A + ORD + 1], SENT_WORD ^ 32'(ORD + 1));
            check("write_count", v, 32'(wr_cnt_a - wb), 32'd10);
        end

        // Separate output buffer
        fill(vecs[0].r, vecs[0].coef);
        wb = wr_cnt_b;
        pulse(1'b1);
        wait_done(1'b1, lat);
        check("outbuf_latency", 0, 32'(lat), 32'd61);
        for (int i = 1; i <= ORD; i++) check("outbuf_elem", i, mem_b[OUT_B + i], 32'h2000_0000);
        bad = 0;
        for (int i = 1; i <= ORD; i++) if (mem_b[IN_A + i] !== vecs[0].r) bad++;
        check("inbuf_untouched", 0, 32'(bad), 32'd0);
        check("out_r0_untouched", 0, mem_b[OUT_B], SENT_WORD ^ 32'd16);
        check("outbuf_writes", 0, 32'(wr_cnt_b - wb), 32'd10);

        // Start while busy at T+20 and in the DONE cycle: both ignored
        fill(vecs[1].r, vecs[1].coef);
        wb = wr_cnt_a;
        db = done_cnt_a;
        pulse(1'b0);
        repeat (19) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done(1'b0, lat);
        check("restart_latency", 0, 32'(lat), 32'd61);
        start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("start_in_done_busy", 0, 32'(busy_a), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("restart_done_count", 0, 32'(done_cnt_a - db), 32'd1);
        check("restart_writes", 0, 32'(wr_cnt_a - wb), 32'd10);
        check("restart_elem", 0, mem_a[IN_A + ORD], vecs[1].exp);

        // Reset at T+25 aborts; a fresh start then completes
        fill(vecs[0].r, vecs[0].coef);
        wb = wr_cnt_a;
        db = done_cnt_a;
        pulse(1'b0);
        repeat (24) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("abort_busy", 0, 32'(busy_a), 32'd0);
        check("abort_we", 0, 32'(we_a), 32'd0);
        repeat (80) @(posedge clk);
        #1;
        check("abort_no_done", 0, 32'(done_cnt_a - db), 32'd0);
        check("abort_writes", 0, 32'(wr_cnt_a - wb), 32'd4);
        fill(vecs[0].r, vecs[0].coef);
        pulse(1'b0);
        wait_done(1'b0, lat);
        check("post_abort_latency", 0, 32'(lat), 32'd61);
        for (int i = 1; i <= ORD; i++) check("post_abort_elem", i, mem_a[IN_A + i], 32'h2000_0000);

        @(posedge clk); #1;
        check("write_range_a", 0, 32'(bad_wr_a), 32'd0);
        check("write_range_b", 0, 32'(bad_wr_b), 32'd0);
        check("coef_addr_track", 0, 32'(addr_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
